// File: rtl/fa_self_tester.sv
// Built-in self tester for a 1-bit full adder.
// Walks all eight input vectors and reports error count and first failure.
module fa_self_tester #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  output logic       FA_A,
  output logic       FA_B,
  output logic       Cin,
  input  logic       FA_S,
  input  logic       Cout,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] ErrCount,
  output logic       FailValid,
  output logic [2:0] FirstFailVec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SetLast = 4'(SETTLE_CYC - 1);

  state_t     state_q;
  logic [2:0] v_q;
  logic [3:0] cnt_q;
  logic       a_q;
  logic       b_q;
  logic       c_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic       fv_q;
  logic [2:0] ffv_q;

  logic       exp_s;
  logic       exp_c;
  logic       mis;
  logic [3:0] err_d;
  logic [2:0] v_d;

  // Response is only consumed in CHECK, so glitches in SETTLE are harmless.
  always_comb begin
    exp_s = a_q ^ b_q ^ c_q;
    exp_c = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
    mis   = (FA_S != exp_s) || (Cout != exp_c);
    err_d = (mis && err_q != 4'd8) ? err_q + 4'd1 : err_q;
    v_d   = v_q + 3'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= SETTLE;
            v_q     <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffv_q   <= '0;
          end
        end
        SETTLE: begin
          if (cnt_q == SetLast) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mis && !fv_q) begin
            fv_q  <= 1'b1;
            ffv_q <= v_q;
          end
          if (v_q == 3'd7) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == 4'd0);
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
          end else begin
            state_q <= SETTLE;
            v_q     <= v_d;
            cnt_q   <= '0;
            {c_q, a_q, b_q} <= v_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign FA_A         = a_q;
  assign FA_B         = b_q;
  assign Cin          = c_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Pass         = pass_q;
  assign ErrCount     = err_q;
  assign FailValid    = fv_q;
  assign FirstFailVec = ffv_q;

endmodule

// File: doc/fa_self_tester.md
FA_SELF_TESTER -- requirements
Module: fa_self_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, legal range 1..15: number of settle cycles per vector before the response is sampled.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: run request, sampled only in IDLE.
REQ-005 SHALL have ports FA_A, FA_B and Cin, each output, 1 bit, registered: stimulus driven to the adder under test.
REQ-006 SHALL have ports FA_S and Cout, each input, 1 bit: response from the adder under test.
REQ-007 SHALL have port Busy, output, 1 bit: high while a run is in progress.
REQ-008 SHALL have port Done, output, 1 bit: one-cycle pulse marking the end of a run.
REQ-009 SHALL have port Pass, output, 1 bit: high when the last completed run had zero mismatches.
REQ-010 SHALL have port ErrCount, output, 4 bits: number of mismatching vectors in the current or last run (0..8).
REQ-011 SHALL have ports FailValid, output, 1 bit, and FirstFailVec, output, 3 bits: FailValid marks that a mismatch occurred; FirstFailVec holds the index of the first mismatching vector.

Function
REQ-012 SHALL implement states IDLE, SETTLE, CHECK and DONE.
REQ-013 SHALL apply vectors with index v = 0..7 in ascending order, using the mapping Cin=v[2], FA_A=v[1], FA_B=v[0].
REQ-014 SHALL, in IDLE with Start=1 at a clock edge, at that edge: enter SETTLE; set v=0; drive vector 0; set Busy=1; clear ErrCount, FailValid, FirstFailVec and Pass.
REQ-015 SHALL hold each vector for SETTLE_CYC cycles in SETTLE, then 1 cycle in CHECK; stimulus outputs SHALL stay stable across both states.
REQ-016 SHALL, in CHECK, compare FA_S against A^B^Cin and Cout against majority(A,B,Cin); a mismatch on either output counts as one error for that vector.
REQ-017 SHALL, on a mismatch, increment ErrCount (saturating at 8); if FailValid=0, set FailValid=1 and FirstFailVec=v.
REQ-018 SHALL, on leaving CHECK with v<7, increment v, drive the next vector and re-enter SETTLE; with v=7, enter DONE.
REQ-019 SHALL, in DONE, for exactly one cycle: Done=1, Busy=0, Pass=(ErrCount==0), stimulus outputs 0; then return to IDLE.
REQ-020 SHALL make Done rise at the edge 8*(SETTLE_CYC+1) edges after the edge that accepted Start (24 edges for default SETTLE_CYC=2).
REQ-021 SHALL drive FA_A, FA_B and Cin to 0 in IDLE and DONE.
REQ-022 SHALL ignore Start in SETTLE, CHECK and DONE; a Start held high SHALL begin a new run on the first IDLE edge after DONE.
REQ-023 SHALL hold Pass, ErrCount, FailValid and FirstFailVec stable in IDLE until the next accepted Start.
REQ-024 SHALL sample FA_S and Cout combinationally in CHECK only; response values in SETTLE SHALL have no effect.

Reset
REQ-025 SHALL, while Rst_n=0, immediately and independent of Clk: force state IDLE and v=0, and drive FA_A, FA_B, Cin, Busy, Done, Pass, ErrCount, FailValid and FirstFailVec to 0.
REQ-026 SHALL, on reset asserted mid-run, abort the run with no Done pulse; after release, remain in IDLE until Start.
REQ-027 SHALL ignore Start on the first edge on which Rst_n=1 only if it coincides with reset deassertion; Start SHALL be accepted from the following edge on.

Verification
REQ-028 Correct full adder, SETTLE_CYC=2, Start pulsed -> vectors 0..7 each held 3 cycles; Done at edge 24; Pass=1, ErrCount=0, FailValid=0.
REQ-029 FA_S stuck at 0 -> mismatches at v=1,2,4,7; ErrCount=4, FirstFailVec=1, FailValid=1, Pass=0.
REQ-030 Cout inverted -> every vector mismatches; ErrCount=8 (no wrap), FirstFailVec=0, Pass=0.
REQ-031 Start re-pulsed at edges 5 and 24 (DONE cycle) -> both ignored, results intact; Start held high through DONE -> new run begins on the following IDLE edge with results cleared.
REQ-032 Rst_n low asynchronously during v=3 SETTLE -> all outputs 0 immediately, no Done pulse; next Start runs from v=0.
REQ-033 SETTLE_CYC=1 and SETTLE_CYC=15 -> Done at edge 16 and edge 128 respectively; glitch on FA_S during SETTLE only -> no error counted.
